// File: rtl/regfile_write_arbiter.sv
// Two-port round-robin arbiter for the register file write port, one holding buffer per port.
// Define REGARB_XZR_DROP_EN to suppress the RegWr pulse for writes to register 31.
module regfile_write_arbiter #(
    parameter int DATA_W = 64
) (
    input  logic              Clk,
    input  logic              ResetL,
    input  logic              Valid0,
    input  logic              Valid1,
    output logic              Ready0,
    output logic              Ready1,
    input  logic [4:0]        Reg0,
    input  logic [4:0]        Reg1,
    input  logic [DATA_W-1:0] Data0,
    input  logic [DATA_W-1:0] Data1,
    output logic              RegWr,
    output logic [4:0]        RW,
    output logic [DATA_W-1:0] BusW,
    output logic [31:0]       PendMask
);

    logic              full0_q, full0_d, full1_q, full1_d;
    logic [4:0]        hreg0_q, hreg0_d, hreg1_q, hreg1_d;
    logic [DATA_W-1:0] hdata0_q, hdata0_d, hdata1_q, hdata1_d;
    logic              old_q, old_d;
    logic              last_gnt_q, last_gnt_d;
    logic              regwr_q, regwr_d;
    logic [4:0]        rw_q, rw_d;
    logic [DATA_W-1:0] busw_q, busw_d;

    logic              gnt0, gnt1, gnt;
    logic              acc0, acc1, keep0, keep1;
    logic [4:0]        sel_reg;
    logic [DATA_W-1:0] sel_data;
    logic [31:0]       pend;

    // old_q = 0: port 0 holds the older entry; last_gnt_q = index of last granted port
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (full0_q && full1_q) begin
            if (hreg0_q == hreg1_q) begin
                gnt0 = !old_q;
            end else begin
                gnt0 = last_gnt_q;
            end
            gnt1 = !gnt0;
        end else begin
            gnt0 = full0_q;
            gnt1 = full1_q;
        end
    end

    always_comb begin
        gnt      = gnt0 | gnt1;
        acc0     = Valid0 && !full0_q;
        acc1     = Valid1 && !full1_q;
        keep0    = full0_q && !gnt0;
        keep1    = full1_q && !gnt1;
        full0_d  = acc0 | keep0;
        full1_d  = acc1 | keep1;
        hreg0_d  = acc0 ? Reg0 : hreg0_q;
        hreg1_d  = acc1 ? Reg1 : hreg1_q;
        hdata0_d = acc0 ? Data0 : hdata0_q;
        hdata1_d = acc1 ? Data1 : hdata1_q;

        old_d = old_q;
        if (keep0 && acc1) begin
            old_d = 1'b0;
        end else if (keep1 && acc0) begin
            old_d = 1'b1;
        end else if (acc0 && acc1) begin
            old_d = 1'b0;
        end

        sel_reg    = gnt1 ? hreg1_q : hreg0_q;
        sel_data   = gnt1 ? hdata1_q : hdata0_q;
        last_gnt_d = gnt ? gnt1 : last_gnt_q;
        rw_d       = gnt ? sel_reg : rw_q;
        busw_d     = gnt ? sel_data : busw_q;
`ifdef REGARB_XZR_DROP_EN
        regwr_d = gnt && (sel_reg != 5'd31);
`else
        regwr_d = gnt;
`endif
    end

    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            full0_q    <= 1'b0;
            full1_q    <= 1'b0;
            hreg0_q    <= '0;
            hreg1_q    <= '0;
            hdata0_q   <= '0;
            hdata1_q   <= '0;
            old_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            regwr_q    <= 1'b0;
            rw_q       <= '0;
            busw_q     <= '0;
        end else begin
            full0_q    <= full0_d;
            full1_q    <= full1_d;
            hreg0_q    <= hreg0_d;
            hreg1_q    <= hreg1_d;
            hdata0_q   <= hdata0_d;
            hdata1_q   <= hdata1_d;
            old_q      <= old_d;
            last_gnt_q <= last_gnt_d;
            regwr_q    <= regwr_d;
            rw_q       <= rw_d;
            busw_q     <= busw_d;
        end
    end

    // X31 is hardwired to zero, so it is never a hazard source
    always_comb begin
        pend = '0;
        if (full0_q) pend[hreg0_q] = 1'b1;
        if (full1_q) pend[hreg1_q] = 1'b1;
        if (regwr_q) pend[rw_q] = 1'b1;
        pend[31] = 1'b0;
    end

    assign Ready0   = !full0_q;
    assign Ready1   = !full1_q;
    assign RegWr    = regwr_q;
    assign RW       = rw_q;
    assign BusW     = busw_q;
    assign PendMask = pend;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: timestamped buffer model vs DUT.
// Follows REGARB_XZR_DROP_EN the same way the design does.
module tb_regfile_write_arbiter;

    typedef struct packed {
        logic [4:0]  r;
        logic [63:0] d;
    } wr_t;

    logic        Clk;
    logic        ResetL;
    logic        Valid0, Valid1;
    logic        Ready0, Ready1;
    logic [4:0]  Reg0, Reg1;
    logic [63:0] Data0, Data1;
    logic        RegWr;
    logic [4:0]  RW;
    logic [63:0] BusW;
    logic [31:0] PendMask;

    int tests;
    int fails;

    wr_t exp_q[$];

    bit          m_full[2];
    logic [4:0]  m_r[2];
    logic [63:0] m_d[2];
    int          m_t[2];
    int          m_last;
    bit          m_wr;
    logic [4:0]  m_rw;
    int          cyc;

    regfile_write_arbiter #(.DATA_W(64)) dut (
        .Clk(Clk), .ResetL(ResetL),
        .Valid0(Valid0), .Valid1(Valid1),
        .Ready0(Ready0), .Ready1(Ready1),
        .Reg0(Reg0), .Reg1(Reg1),
        .Data0(Data0), .Data1(Data1),
        .RegWr(RegWr), .RW(RW), .BusW(BusW),
        .PendMask(PendMask)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic bit drops(logic [4:0] r);
`ifdef REGARB_XZR_DROP_EN
        return r == 5'd31;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_pend();
        logic [31:0] p;
        p = '0;
        for (int i = 0; i < 2; i++)
            if (m_full[i] && !drops(m_r[i])) p[m_r[i]] = 1'b1;
        if (m_wr) p[m_rw] = 1'b1;
        p[31] = 1'b0;
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 0;
            m_t[i]    = 0;
        end
        m_last = 1;
        m_wr   = 0;
        m_rw   = '0;
        exp_q.delete();
    endtask

    // One clock edge of the reference: age by load time, round-robin otherwise
    task automatic step_model();
        int g;
        bit a0, a1;
        g = -1;
        if (m_full[0] && m_full[1]) begin
            if (m_r[0] == m_r[1]) g = (m_t[0] <= m_t[1]) ? 0 : 1;
            else g = (m_last == 0) ? 1 : 0;
        end else if (m_full[0]) g = 0;
        else if (m_full[1]) g = 1;
        a0 = Valid0 && !m_full[0];
        a1 = Valid1 && !m_full[1];
        m_wr = 0;
        if (g >= 0) begin
            m_full[g] = 0;
            m_last = g;
            m_wr = !drops(m_r[g]);
            m_rw = m_r[g];
            if (m_wr) exp_q.push_back('{r: m_r[g], d: m_d[g]});
        end
        if (a0) begin
            m_full[0] = 1; m_r[0] = Reg0; m_d[0] = Data0; m_t[0] = cyc;
        end
        if (a1) begin
            m_full[1] = 1; m_r[1] = Reg1; m_d[1] = Data1; m_t[1] = cyc;
        end
        cyc++;
    endtask

    task automatic cycle();
        @(posedge Clk);
        if (ResetL) step_model();
        @(negedge Clk);
        #1;
    endtask

    task automatic cycle_then_reset();
        @(posedge Clk);
        if (ResetL) step_model();
        #1;
        ResetL = 1'b0;
        model_reset();
        @(negedge Clk);
        #1;
        cycle();
        ResetL = 1'b1;
    endtask

    task automatic idle(int n);
        Valid0 = 0;
        Valid1 = 0;
        repeat (n) cycle();
    endtask

    // Monitor: compare presented writes against the scoreboard, plus ready/mask
    always @(negedge Clk) begin
        if (!ResetL) begin
            chk("rst_regwr", 64'(RegWr), 64'd0);
            chk("rst_ready0", 64'(Ready0), 64'd1);
            chk("rst_ready1", 64'(Ready1), 64'd1);
            chk("rst_pend", 64'(PendMask), 64'd0);
            chk("rst_rw", 64'(RW), 64'd0);
            chk("rst_busw", BusW, 64'd0);
        end else begin
            chk("ready0", 64'(Ready0), 64'(!m_full[0]));
            chk("ready1", 64'(Ready1), 64'(!m_full[1]));
            chk("pendmask", 64'(PendMask), 64'(model_pend()));
            if (RegWr) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_rw", 64'(RW), 64'h3f);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("write_rw", 64'(RW), 64'(e.r));
                    chk("write_busw", BusW, e.d);
                end
            end else begin
                chk("missing_write", 64'(exp_q.size()), 64'd0);
                exp_q.delete();
            end
        end
    end

    initial begin
        logic [4:0] regs[4];
        regs[0] = 5'd1; regs[1] = 5'd2; regs[2] = 5'd7; regs[3] = 5'd31;
        tests = 0;
        fails = 0;
        cyc = 0;
        model_reset();
        ResetL = 1'b0;
        Valid0 = 1; Reg0 = 5'd5; Data0 = 64'hA5;
        Valid1 = 0; Reg1 = 5'd0; Data1 = '0;
        repeat (3) cycle();
        ResetL = 1'b1;
        cycle();
        Valid0 = 0;
        idle(3);

        Valid0 = 1; Valid1 = 1; Reg0 = 5'd1; Reg1 = 5'd2;
        for (int i = 0; i < 8; i++) begin
            Data0 = {$urandom, $urandom};
            Data1 = {$urandom, $urandom};
            cycle();
        end
        idle(3);

        Valid1 = 1; Reg1 = 5'd7; Data1 = 64'h11;
        cycle();
        Valid1 = 0;
        Valid0 = 1; Reg0 = 5'd7; Data0 = 64'h22;
        cycle();
        idle(3);

        Valid0 = 1; Reg0 = 5'd3; Data0 = 64'h1234;
        Valid1 = 1; Reg1 = 5'd3; Data1 = 64'h5678;
        for (int i = 0; i < 6; i++) begin
            Data0 = Data0 + 1;
            cycle();
        end
        idle(3);

        Valid0 = 1; Reg0 = 5'd31; Data0 = 64'hdead;
        cycle();
        idle(3);

        Valid0 = 1; Valid1 = 1; Reg0 = 5'd9; Reg1 = 5'd10;
        Data0 = 64'h99; Data1 = 64'haa;
        cycle();
        cycle_then_reset();
        idle(4);

        for (int i = 0; i < 3000; i++) begin
            Valid0 = 1'($urandom_range(0, 1));
            Valid1 = 1'($urandom_range(0, 1));
            Reg0 = ($urandom_range(0, 2) == 0) ? 5'($urandom) : regs[$urandom_range(0, 3)];
            Reg1 = ($urandom_range(0, 2) == 0) ? 5'($urandom) : regs[$urandom_range(0, 3)];
            Data0 = {$urandom, $urandom};
            Data1 = {$urandom, $urandom};
            if ($urandom_range(0, 399) == 0) cycle_then_reset();
            else cycle();
        end
        idle(5);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
